dds_sweep_ctrl: RTL

DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

---
 rtl/dds_sweep_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller: steps a phase increment from a start value
// to a stop value (single, repeating or up-down) with a programmable dwell.
module dds_sweep_ctrl #(
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [PHASE_WIDTH-1:0] cfg_start_inc_i,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_inc_i,
    input  logic [PHASE_WIDTH-1:0] cfg_step_i,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic [PHASE_WIDTH-1:0] phase_inc_o,
    output logic                   busy_o,
    output logic                   step_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;

    state_t                 state;
    logic [PHASE_WIDTH-1:0] start_r;
    logic [PHASE_WIDTH-1:0] stop_r;
    logic [PHASE_WIDTH-1:0] step_r;
    logic [DWELL_WIDTH-1:0] dwell_r;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [1:0]             mode_r;

    logic                   cfg_hs;
    logic [PHASE_WIDTH-1:0] cfg_stop_eff;
    logic [PHASE_WIDTH-1:0] cfg_step_eff;
    logic [PHASE_WIDTH:0]   up_sum;
    logic [PHASE_WIDTH-1:0] up_next;
    logic [PHASE_WIDTH-1:0] down_diff;
    logic [PHASE_WIDTH-1:0] down_next;
    logic                   dwell_done;

    // State decodes are taken straight from the state register
    assign cfg_ready_o = (state == IDLE);
    assign busy_o      = (state != IDLE);

    // Abort outranks a configuration handshake as well
    assign cfg_hs     = cfg_valid_i && cfg_ready_o && !abort_i;
    assign dwell_done = (dwell_cnt == dwell_r);

    // Configuration normalisation and saturating next-step arithmetic
    always_comb begin
        cfg_stop_eff = (cfg_stop_inc_i > cfg_start_inc_i) ? cfg_stop_inc_i : cfg_start_inc_i;
        cfg_step_eff = (cfg_step_i == '0) ? PHASE_WIDTH'(1) : cfg_step_i;

        up_sum  = {1'b0, phase_inc_o} + {1'b0, step_r};
        up_next = (up_sum > {1'b0, stop_r}) ? stop_r : up_sum[PHASE_WIDTH-1:0];

        down_diff = phase_inc_o - step_r;
        if ((phase_inc_o < step_r) || (down_diff < start_r)) begin
            down_next = start_r;
        end else begin
            down_next = down_diff;
        end
    end

    // Sweep FSM with registered phase increment and pulse outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            phase_inc_o <= '0;
            step_o      <= 1'b0;
            done_o      <= 1'b0;
            dwell_cnt   <= '0;
            start_r     <= '0;
            stop_r      <= '0;
            step_r      <= '0;
            dwell_r     <= '0;
            mode_r      <= '0;
        end else begin
            step_o <= 1'b0;
            done_o <= 1'b0;
            if (abort_i) begin
                state       <= IDLE;
                phase_inc_o <= '0;
                dwell_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cfg_hs) begin
                            start_r <= cfg_start_inc_i;
                            stop_r  <= cfg_stop_eff;
                            step_r  <= cfg_step_eff;
                            dwell_r <= cfg_dwell_i;
                            mode_r  <= cfg_mode_i;
                        end
                        if (start_i) begin
                            state       <= RUN_UP;
                            phase_inc_o <= cfg_hs ? cfg_start_inc_i : start_r;
                            dwell_cnt   <= '0;
                        end
                    end
                    RUN_UP: begin
                        if (!dwell_done) begin
                            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                        end else begin
                            dwell_cnt <= '0;
                            if (phase_inc_o < stop_r) begin
                                phase_inc_o <= up_next;
                                step_o      <= 1'b1;
                            end else begin
                                case (mode_r)
                                    MODE_REPEAT: begin
                                        phase_inc_o <= start_r;
                                        step_o      <= 1'b1;
                                    end
                                    MODE_UPDOWN: state <= RUN_DOWN;
                                    default: begin
                                        state  <= DONE;
                                        done_o <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    RUN_DOWN: begin
                        if (!dwell_done) begin
                            dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                        end else begin
                            dwell_cnt <= '0;
                            if (phase_inc_o > start_r) begin
                                phase_inc_o <= down_next;
                                step_o      <= 1'b1;
                            end else begin
                                state <= RUN_UP;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
